// File: rtl/i2c_slave_regif.sv
// I2C target front-end for a local register file.
// Oversamples SCL/SDA in the clk domain, decodes START/STOP, address, register
// pointer and data bytes, ACKs its own address, emits one-cycle write strobes and
// serves read bytes from a combinational register-file port.
//
// Ports:
//   i_clk       system clock, at least 8x the SCL frequency
//   i_reset     synchronous, active-high reset
//   i_scl_in    raw SCL from the bus
//   i_sda_in    raw SDA from the bus
//   o_sda_oe    1 = pull SDA low, 0 = release
//   o_wr_en     one-cycle write strobe
//   o_wr_addr   register address for the write
//   o_wr_data   write data
//   o_rd_addr   current register pointer
//   i_rd_data   register file data at o_rd_addr (combinational)
//   o_busy      high from an addressed START until STOP, NACK or mismatch
module i2c_slave_regif #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_scl_in,
  input  logic       i_sda_in,
  output logic       o_sda_oe,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic [7:0] o_rd_addr,
  input  logic [7:0] i_rd_data,
  output logic       o_busy
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StReg, StRegAck,
    StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
  } state_e;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_hist, r_sda_hist;
  state_e                 r_state, w_state_nxt;
  logic [3:0]             r_cnt, w_cnt_nxt;
  logic [7:0]             r_shift, w_shift_nxt;
  logic [7:0]             r_ptr, w_ptr_nxt;
  logic                   r_rw, w_rw_nxt;
  logic                   r_phase, w_phase_nxt;  // ACK sub-phase / master-ACK seen
  logic                   r_sda_oe, w_sda_oe_nxt;
  logic                   r_wr_en, w_wr_en_nxt;
  logic [7:0]             r_wr_addr, w_wr_addr_nxt;
  logic [7:0]             r_wr_data, w_wr_data_nxt;
  logic                   r_busy, w_busy_nxt;

  logic       w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_hist;
  assign w_scl_fall = ~w_scl & r_scl_hist;
  // SCL must be high in both samples so an SCL edge is never mistaken for START/STOP
  assign w_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
  assign w_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
      r_state    <= StIdle;
      r_cnt      <= 4'd0;
      r_shift    <= 8'd0;
      r_ptr      <= 8'd0;
      r_rw       <= 1'b0;
      r_phase    <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 8'd0;
      r_wr_data  <= 8'd0;
      r_busy     <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda_in};
      r_scl_hist <= w_scl;
      r_sda_hist <= w_sda;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_ptr      <= w_ptr_nxt;
      r_rw       <= w_rw_nxt;
      r_phase    <= w_phase_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_shift_nxt   = r_shift;
    w_ptr_nxt     = r_ptr;
    w_rw_nxt      = r_rw;
    w_phase_nxt   = r_phase;
    w_sda_oe_nxt  = r_sda_oe;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_busy_nxt    = r_busy;

    if (w_start) begin
      w_state_nxt  = StAddr;
      w_cnt_nxt    = 4'd0;
      w_phase_nxt  = 1'b0;
      w_sda_oe_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = StIdle;
      w_phase_nxt  = 1'b0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StIgnore: w_sda_oe_nxt = 1'b0;

        StAddr, StReg, StWdata: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt   = 4'd0;
              w_phase_nxt = 1'b0;
              if (r_state == StAddr) begin
                if (w_byte[7:1] == SLAVE_ADDR) begin
                  w_rw_nxt    = w_byte[0];
                  w_busy_nxt  = 1'b1;
                  w_state_nxt = StAddrAck;
                end else begin
                  w_busy_nxt  = 1'b0;
                  w_state_nxt = StIgnore;
                end
              end else if (r_state == StReg) begin
                w_ptr_nxt   = w_byte;
                w_state_nxt = StRegAck;
              end else begin
                // Strobe lands the cycle after the 8th rise, pointer advances with it
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = r_ptr;
                w_wr_data_nxt = w_byte;
                w_ptr_nxt     = r_ptr + 8'd1;
                w_state_nxt   = StWdataAck;
              end
            end
          end
        end

        StAddrAck, StRegAck, StWdataAck: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_oe_nxt = 1'b1;
              w_phase_nxt  = 1'b1;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_phase_nxt  = 1'b0;
              w_cnt_nxt    = 4'd0;
              if (r_state == StAddrAck && r_rw) begin
                w_shift_nxt  = i_rd_data;
                w_sda_oe_nxt = ~i_rd_data[7];
                w_state_nxt  = StRdata;
              end else if (r_state == StAddrAck) begin
                w_state_nxt = StReg;
              end else begin
                w_state_nxt = StWdata;
              end
            end
          end
        end

        StRdata: begin
          if (w_scl_fall) begin
            if (r_cnt == 4'd7) begin
              w_sda_oe_nxt = 1'b0;
              w_cnt_nxt    = 4'd0;
              w_phase_nxt  = 1'b0;
              w_state_nxt  = StRdataAck;
            end else begin
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[6];
              w_cnt_nxt    = r_cnt + 4'd1;
            end
          end
        end

        StRdataAck: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_ptr_nxt   = r_ptr + 8'd1;
              w_phase_nxt = 1'b1;
            end else begin
              w_busy_nxt  = 1'b0;
              w_state_nxt = StIgnore;
            end
          end else if (w_scl_fall && r_phase) begin
            w_shift_nxt  = i_rd_data;
            w_sda_oe_nxt = ~i_rd_data[7];
            w_cnt_nxt    = 4'd0;
            w_phase_nxt  = 1'b0;
            w_state_nxt  = StRdata;
          end
        end

        default: begin
          w_state_nxt  = StIdle;
          w_sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  assign o_sda_oe  = r_sda_oe;
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_rd_addr = r_ptr;
  assign o_busy    = r_busy;

endmodule
